// File: rtl/instr_dispatch_ctrl.sv
// instr_dispatch_ctrl
// Instruction front-end for the matrix coprocessor. Incoming instructions are
// queued in a small FIFO, then a FETCH/DECODE/EXECUTE/RETIRE machine hands
// each one to a functional unit over a start/done handshake. Illegal opcodes
// and units that never answer are reported as one-cycle error pulses.
module instr_dispatch_ctrl #(
  parameter int INSTR_W     = 32,
  parameter int OPCODE_W    = 4,
  parameter int NUM_UNITS   = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [INSTR_W-1:0]            instr_in,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [INSTR_W-1:0]            exec_instr,
  output logic [NUM_UNITS-1:0]          unit_start,
  input  logic [NUM_UNITS-1:0]          unit_done,
  output logic                          busy,
  output logic                          retire_pulse,
  output logic                          err_illegal,
  output logic                          err_timeout,
  output logic [CNT_W-1:0]              retired_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  // Counter only has to reach TIMEOUT_CYC-1; keep at least one bit when disabled.
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic [AW:0]     FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_RETIRE  = 2'd3
  } state_t;

  // Opcode 1..NUM_UNITS addresses a unit; 0 and anything above are illegal.
  function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
    return (op != {OPCODE_W{1'b0}}) && (int'(op) <= NUM_UNITS);
  endfunction

  // One-hot start vector for a legal opcode (unit index is opcode-1).
  function automatic logic [NUM_UNITS-1:0] op_to_onehot(input logic [OPCODE_W-1:0] op);
    return NUM_UNITS'(1'b1) << (op - OPCODE_W'(1'b1));
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------------
  logic [INSTR_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        level_r;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;

  // ---------------------------------------------------------------------------
  // Dispatch state
  // ---------------------------------------------------------------------------
  state_t              state_r;
  logic [INSTR_W-1:0]  exec_instr_r;
  logic [NUM_UNITS-1:0] unit_start_r;
  logic [TO_W-1:0]     to_cnt_r;
  logic                retire_pulse_r;
  logic                err_illegal_r;
  logic                err_timeout_r;
  logic [CNT_W-1:0]    retired_cnt_r;

  logic [OPCODE_W-1:0]  op_s;
  logic                 op_legal_s;
  logic [NUM_UNITS-1:0] op_onehot_s;
  logic                 done_hit_s;
  logic                 to_expire_s;

  assign full_s  = (level_r == FULL_LVL);
  assign empty_s = (level_r == {(AW + 1){1'b0}});
  // No bypass: an instruction written on this edge is only visible next cycle.
  assign push_s  = instr_valid && !full_s;
  assign pop_s   = (state_r == S_FETCH) && !empty_s;

  assign op_s        = exec_instr_r[OPCODE_W-1:0];
  assign op_legal_s  = op_is_legal(op_s);
  assign op_onehot_s = op_to_onehot(op_s);
  // unit_start is one-hot for the executing opcode, so masking picks out
  // exactly the done bit of the active unit and ignores all others.
  assign done_hit_s  = |(unit_done & unit_start_r);
  assign to_expire_s = (TIMEOUT_CYC != 0) && (to_cnt_r == TO_LAST);

  // Queue payload storage, written on every accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= instr_in;
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop leave level unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + (AW + 1)'(1'b1);
        2'b01:   level_r <= level_r - (AW + 1)'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Dispatch FSM with registered start, pulse and counter outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= S_FETCH;
      exec_instr_r   <= {INSTR_W{1'b0}};
      unit_start_r   <= {NUM_UNITS{1'b0}};
      to_cnt_r       <= {TO_W{1'b0}};
      retire_pulse_r <= 1'b0;
      err_illegal_r  <= 1'b0;
      err_timeout_r  <= 1'b0;
      retired_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      retire_pulse_r <= 1'b0;
      err_illegal_r  <= 1'b0;
      err_timeout_r  <= 1'b0;
      case (state_r)
        S_FETCH: begin
          if (!empty_s) begin
            exec_instr_r <= mem_r[rd_ptr_r];
            state_r      <= S_DECODE;
          end else begin
            state_r      <= S_FETCH;
          end
        end
        S_DECODE: begin
          to_cnt_r <= {TO_W{1'b0}};
          if (op_legal_s) begin
            unit_start_r <= op_onehot_s;
            state_r      <= S_EXECUTE;
          end else begin
            err_illegal_r <= 1'b1;
            state_r       <= S_FETCH;
          end
        end
        S_EXECUTE: begin
          // Done is checked first so it wins over a coinciding timeout.
          if (done_hit_s) begin
            unit_start_r   <= {NUM_UNITS{1'b0}};
            retire_pulse_r <= 1'b1;
            retired_cnt_r  <= retired_cnt_r + CNT_W'(1'b1);
            state_r        <= S_RETIRE;
          end else if (to_expire_s) begin
            unit_start_r  <= {NUM_UNITS{1'b0}};
            err_timeout_r <= 1'b1;
            state_r       <= S_FETCH;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1'b1);
          end
        end
        S_RETIRE: begin
          state_r <= S_FETCH;
        end
        default: begin
          unit_start_r <= {NUM_UNITS{1'b0}};
          state_r      <= S_FETCH;
        end
      endcase
    end
  end

  assign instr_ready   = !full_s;
  assign fifo_level    = level_r;
  assign exec_instr    = exec_instr_r;
  assign unit_start    = unit_start_r;
  assign busy          = (state_r != S_FETCH) || !empty_s;
  assign retire_pulse  = retire_pulse_r;
  assign err_illegal   = err_illegal_r;
  assign err_timeout   = err_timeout_r;
  assign retired_count = retired_cnt_r;

endmodule

// File: tb/tb_instr_dispatch_ctrl.sv
// Bench for instr_dispatch_ctrl: randomized host/unit stimulus compared every
// cycle against a transaction-style reference model (instruction queue plus
// the lifetime of the instruction in flight).
module tb_instr_dispatch_ctrl;

  localparam int INSTR_W     = 32;
  localparam int OPCODE_W    = 4;
  localparam int NUM_UNITS   = 12;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int CNT_W       = 4;
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [INSTR_W-1:0]   instr_in;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [LVL_W-1:0]     fifo_level;
  logic [INSTR_W-1:0]   exec_instr;
  logic [NUM_UNITS-1:0] unit_start;
  logic [NUM_UNITS-1:0] unit_done;
  logic                 busy;
  logic                 retire_pulse;
  logic                 err_illegal;
  logic                 err_timeout;
  logic [CNT_W-1:0]     retired_count;

  always #5 clk = ~clk;

  instr_dispatch_ctrl #(
    .INSTR_W(INSTR_W), .OPCODE_W(OPCODE_W), .NUM_UNITS(NUM_UNITS),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fifo_level(fifo_level), .exec_instr(exec_instr),
    .unit_start(unit_start), .unit_done(unit_done), .busy(busy),
    .retire_pulse(retire_pulse), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .retired_count(retired_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];      // instructions accepted but not yet popped
  logic [31:0] host_q[$];   // instructions the host still wants to send
  bit          m_active;    // an instruction has been popped and not finished
  bit          m_retiring;
  logic [31:0] m_cur;
  int          m_age;       // edges since the pop
  int          m_exec_edges;
  bit          m_retire_p, m_illegal_p, m_timeout_p, m_pushed;
  int          m_retired;

  function automatic bit legal(input int op);
    return (op >= 1) && (op <= NUM_UNITS);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 0; m_retiring = 0; m_cur = 32'd0; m_age = 0; m_exec_edges = 0;
    m_retire_p = 0; m_illegal_p = 0; m_timeout_p = 0; m_pushed = 0; m_retired = 0;
  endtask

  task automatic model_edge();
    int op;
    m_pushed = instr_valid && (m_q.size() < FIFO_DEPTH);
    m_retire_p = 0; m_illegal_p = 0; m_timeout_p = 0;
    if (!m_active) begin
      if (m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_active = 1; m_retiring = 0; m_age = 0; m_exec_edges = 0;
      end
    end else begin
      op = int'(m_cur[OPCODE_W-1:0]);
      m_age++;
      if (m_age == 1) begin
        if (!legal(op)) begin
          m_illegal_p = 1;
          m_active = 0;
        end
      end else if (m_retiring) begin
        m_active = 0;
      end else begin
        m_exec_edges++;
        if (unit_done[op-1]) begin
          m_retiring = 1;
          m_retire_p = 1;
          m_retired = (m_retired + 1) % (1 << CNT_W);
        end else if (m_exec_edges == TIMEOUT_CYC) begin
          m_timeout_p = 1;
          m_active = 0;
        end
      end
    end
    if (m_pushed) m_q.push_back(instr_in);
  endtask

  task automatic check_all();
    int op;
    logic [NUM_UNITS-1:0] exp_start;
    exp_start = {NUM_UNITS{1'b0}};
    if (m_active && (m_age >= 1) && !m_retiring) begin
      op = int'(m_cur[OPCODE_W-1:0]);
      exp_start = NUM_UNITS'(1) << (op - 1);
    end
    check_value("instr_ready",   32'(instr_ready),   32'(m_q.size() < FIFO_DEPTH));
    check_value("fifo_level",    32'(fifo_level),    32'(m_q.size()));
    check_value("exec_instr",    exec_instr,         m_cur);
    check_value("unit_start",    32'(unit_start),    32'(exp_start));
    check_value("busy",          32'(busy),          32'(m_active || (m_q.size() > 0)));
    check_value("retire_pulse",  32'(retire_pulse),  32'(m_retire_p));
    check_value("err_illegal",   32'(err_illegal),   32'(m_illegal_p));
    check_value("err_timeout",   32'(err_timeout),   32'(m_timeout_p));
    check_value("retired_count", 32'(retired_count), 32'(m_retired));
  endtask

  function automatic logic [31:0] rand_instr(input int illegal_pct);
    logic [31:0] v;
    int pick;
    v = $urandom();
    if ($urandom_range(0, 99) < illegal_pct) begin
      pick = $urandom_range(0, 3);
      v[OPCODE_W-1:0] = (pick == 0) ? 4'd0 : 4'(12 + pick);
    end else begin
      v[OPCODE_W-1:0] = 4'($urandom_range(1, NUM_UNITS));
    end
    return v;
  endfunction

  function automatic logic [31:0] with_op(input int op);
    logic [31:0] v;
    v = $urandom();
    v[OPCODE_W-1:0] = 4'(op);
    return v;
  endfunction

  // One clock: drive inputs, advance the model on the edge, check on negedge.
  task automatic step(input int valid_pct, input logic [NUM_UNITS-1:0] done_force, input int done_pct);
    instr_valid = (host_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
    instr_in    = (host_q.size() > 0) ? host_q[0] : $urandom();
    for (int b = 0; b < NUM_UNITS; b++)
      unit_done[b] = done_force[b] | ($urandom_range(0, 99) < done_pct);
    @(posedge clk);
    if (reset_n) model_edge();
    if (m_pushed) void'(host_q.pop_front());
    @(negedge clk);
    check_all();
  endtask

  // Reset asserted in the middle of a cycle, checked before the next edge.
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    host_q.delete();
    #1;
    check_value("rst_async_start", 32'(unit_start), 32'd0);
    check_all();
    @(negedge clk);
    check_all();
    instr_valid = 1'b0;
    unit_done   = {NUM_UNITS{1'b0}};
    reset_n     = 1'b1;
  endtask

  localparam logic [NUM_UNITS-1:0] NO_DONE  = 12'h000;
  localparam logic [NUM_UNITS-1:0] ALL_DONE = 12'hfff;

  initial begin
    int vp;
    int dp;
    reset_n = 1'b0; instr_valid = 1'b0; instr_in = 32'd0; unit_done = NO_DONE;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;

    // Single READ: unit 0 answers three cycles after its start.
    host_q.push_back(with_op(1));
    for (int i = 0; i < 10; i++) step(100, (i == 5) ? 12'h001 : NO_DONE, 0);
    check_value("first_retired", 32'(retired_count), 32'd1);

    // Five back-to-back pushes, no done: queue fills, every instruction times out.
    for (int i = 0; i < 5; i++) host_q.push_back(rand_instr(0));
    for (int i = 0; i < 60; i++) step(100, NO_DONE, 0);

    // Illegal opcodes 0 and 15, then a legal one.
    host_q.push_back(with_op(0));
    host_q.push_back(with_op(15));
    host_q.push_back(with_op(3));
    for (int i = 0; i < 16; i++) step(100, ALL_DONE, 0);

    // Opcode 5 executing, a foreign done bit is ignored, then async reset.
    host_q.push_back(with_op(5));
    for (int i = 0; i < 3; i++) step(100, NO_DONE, 0);
    for (int i = 0; i < 2; i++) step(100, 12'h004, 0);
    step(100, NO_DONE, 0);
    async_reset();

    // Seventeen retirements wrap a 4-bit counter to 1.
    for (int i = 0; i < 17; i++) host_q.push_back(rand_instr(0));
    for (int i = 0; i < 100; i++) step(100, ALL_DONE, 0);
    check_value("retired_wrap", 32'(retired_count), 32'd1);

    // Random traffic with varying host rate, done density and occasional resets.
    for (int r = 0; r < 30; r++) begin
      vp = $urandom_range(20, 100);
      dp = $urandom_range(0, 40);
      for (int k = 0; k < 8; k++) host_q.push_back(rand_instr(20));
      for (int c = 0; c < 60; c++) step(vp, NO_DONE, dp);
      if ((r % 10) == 9) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
